gin_scatter_fifo: RTL and testbench
===================================

# gin_scatter_fifo

Scatter-side global network for the PE array. A tag FIFO and a data FIFO feed a multicast delivery engine. Each packet's head tag (row_tag, col_tag) is compared against every PE's configured row_id/col_id, and the data word is delivered with a one-cycle enable to every matching PE once all of them are ready. This block sits between the global buffer and the PE array, opposite the gather network that collects PE outputs.

## Interface
- DATA_WIDTH, 64, payload word width
- ROW_TAG_WIDTH, 4, row tag/id width
- COL_TAG_WIDTH, 4, column tag/id width
- NUM_OF_ROWS, 12, PE rows
- NUM_OF_COLS, 14, PE columns
- GIN_FIFO_DEPTH, 16, entries per internal FIFO (power of two, ≥2)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- row_tag  in  ROW_TAG_WIDTH  destination row tag, captured with tags_wr_en
- col_tag  in  COL_TAG_WIDTH  destination column tag, captured with tags_wr_en
- tags_wr_en  in  1  push {col_tag,row_tag}; ignored when tags_full
- tags_full  out  1  tag FIFO full
- data_in  in  DATA_WIDTH  payload, captured with data_wr_en
- data_wr_en  in  1  push data_in; ignored when data_full
- data_full  out  1  data FIFO full
- row_id  in  [NUM_OF_ROWS] × ROW_TAG_WIDTH  configured row id per row
- col_id  in  [NUM_OF_ROWS][NUM_OF_COLS] × COL_TAG_WIDTH  configured column id per PE
- ready_in  in  [NUM_OF_ROWS] × NUM_OF_COLS  PE can accept one word
- data_out  out  DATA_WIDTH  broadcast payload to all PEs
- enable_out  out  [NUM_OF_ROWS] × NUM_OF_COLS  one-cycle write strobe per PE
- drop_pulse  out  1  one-cycle pulse: head packet matched no PE and was discarded

## Operation
- Match per PE: hit[r][c] = (row_id[r]==head_row) && (col_id[r][c]==head_col). Computed combinationally from the FIFO heads.
- pending = ~tags_empty & ~data_empty. Tags and data pair strictly in FIFO order.
- can_send = pending & any(hit) & AND over all hit PEs of ready_in.
- FSM states:
  - GIN_IDLE: no pending packet.
  - GIN_WAIT: pending, but a targeted PE is not ready.
  - GIN_SEND: registered enable cycle.
- Transitions, evaluated every cycle:
  - can_send → GIN_SEND. Pop both FIFOs; register data_out = data head and enable_out = hit.
  - else pending & ~any(hit) → pop both FIFOs, drop_pulse=1 next cycle, next state GIN_IDLE.
  - else pending → GIN_WAIT.
  - else → GIN_IDLE.
- From GIN_SEND, the same evaluation on the next head allows back-to-back sends, one packet per cycle.
- Non-targeted PEs never see enable. data_out holds its last value when no send occurs.
- Simultaneous push and pop on the same FIFO in the same cycle is legal, including when full (pop frees the slot, push accepted) and when empty (push only).
- FIFO pointers wrap modulo GIN_FIFO_DEPTH. Use an extra pointer bit to separate full from empty.

## Timing
- Reset values: enable_out all 0, data_out 0, drop_pulse 0, tags_full/data_full 0, both FIFOs empty, state GIN_IDLE.
- A push at edge N makes the head visible after edge N. The earliest enable_out is the cycle after edge N+1, so write-to-enable latency is 2 cycles.
- ready_in is sampled in the decision cycle. enable_out asserts for exactly one cycle after the pop edge, and the PE captures data_out in that cycle.
- A PE asserting ready_in guarantees space for one word, independent of a later ready_in drop.
- Reset asserted mid-operation flushes both FIFOs. enable_out is 0 in the cycle after the reset edge, and no partial packet survives.

## Configuration
- GIN_BROADCAST_EN defined: an all-ones row_tag matches every row, and an all-ones col_tag matches every column in the targeted rows. The all-ones pair reaches all PEs.
- Not defined: all-ones tags are compared literally like any other value.

## Structure
- Package gin_pkg holds:
  - typedef gin_state_t {GIN_IDLE, GIN_WAIT, GIN_SEND}
  - the wildcard-tag constant function
  - default width localparams
- Sub-module gin_sync_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, active-low reset, and full/empty outputs. It is instantiated twice, once for tags (width ROW+COL) and once for data.
- Match logic and FSM stay in the top level.

## Test plan
- Push tag (3,5) and data 0xA5A5; the PE with row_id=3, col_id=5 is ready → enable_out is asserted only at that PE, 2 cycles after the push, with data_out=0xA5A5.
- Two PEs configured (3,5); one has ready_in=0 for 4 cycles → the FSM stays in GIN_WAIT for 4 cycles, then both enables pulse in the same cycle.
- Tag (9,9) with no matching PE → drop_pulse for one cycle, no enable, and the next packet is delivered normally.
- Fill 16 tags and 16 data words → full flags asserted and a 17th push ignored. Drain with all PEs ready → 16 consecutive single-cycle sends, in order.
- With GIN_BROADCAST_EN defined, tag (0xF,0xF) → all 168 enables pulse together. Without it, the same tag → drop_pulse.
- Reset driven low during back-to-back sends → the next cycle has enable_out=0, both FIFOs empty, and later pushes deliver correctly.

Source files
------------

// File: rtl/gin_pkg.sv
// ============================================================================
// Module      : gin_pkg
// Description : Shared types, default widths and the wildcard-tag helper for
//               the scatter-side global network.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gin_pkg;

    localparam int c_gin_data_width    = 64;
    localparam int c_gin_row_tag_width = 4;
    localparam int c_gin_col_tag_width = 4;
    localparam int c_gin_num_rows      = 12;
    localparam int c_gin_num_cols      = 14;
    localparam int c_gin_fifo_depth    = 16;

    typedef enum logic [1:0] {
        GIN_IDLE = 2'd0,
        GIN_WAIT = 2'd1,
        GIN_SEND = 2'd2
    } gin_state_t;

    // All-ones pattern of the given width; callers truncate to their tag width.
    function automatic logic [31:0] gin_wildcard(input int unsigned width);
        if (width >= 32)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gin_sync_fifo.sv
// ============================================================================
// Module      : gin_sync_fifo
// Description : Synchronous show-ahead FIFO, active-low reset, full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gin_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int           c_aw  = $clog2(DEPTH);
    localparam logic [c_aw:0] c_one = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // The extra MSB on each pointer distinguishes a full ring from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign w_pop  = i_rd_en & ~w_empty;
    assign w_push = i_wr_en & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_one;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push)
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

`default_nettype wire

// File: rtl/gin_scatter_fifo.sv
// ============================================================================
// Module      : gin_scatter_fifo
// Description : Scatter global network: tag/data FIFOs feeding a multicast
//               delivery engine. Optional macro GIN_BROADCAST_EN enables
//               all-ones wildcard tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gin_scatter_fifo
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH     = c_gin_data_width,
    parameter int ROW_TAG_WIDTH  = c_gin_row_tag_width,
    parameter int COL_TAG_WIDTH  = c_gin_col_tag_width,
    parameter int NUM_OF_ROWS    = c_gin_num_rows,
    parameter int NUM_OF_COLS    = c_gin_num_cols,
    parameter int GIN_FIFO_DEPTH = c_gin_fifo_depth
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic [ROW_TAG_WIDTH-1:0]                                  row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                                  col_tag,
    input  logic                                                      tags_wr_en,
    output logic                                                      tags_full,
    input  logic [DATA_WIDTH-1:0]                                     data_in,
    input  logic                                                      data_wr_en,
    output logic                                                      data_full,
    input  logic [NUM_OF_ROWS-1:0][ROW_TAG_WIDTH-1:0]                 row_id,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] col_id,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                   ready_in,
    output logic [DATA_WIDTH-1:0]                                     data_out,
    output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0]                   enable_out,
    output logic                                                      drop_pulse
);

    localparam int c_tag_width = ROW_TAG_WIDTH + COL_TAG_WIDTH;

    logic [c_tag_width-1:0]                 w_tag_head;
    logic [DATA_WIDTH-1:0]                  w_data_head;
    logic                                   w_tags_empty;
    logic                                   w_data_empty;
    logic [ROW_TAG_WIDTH-1:0]               w_head_row;
    logic [COL_TAG_WIDTH-1:0]               w_head_col;
    logic                                   w_row_wild;
    logic                                   w_col_wild;
    logic [NUM_OF_ROWS-1:0]                 w_row_hit;
    logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] w_hit;
    logic                                   w_pending;
    logic                                   w_any_hit;
    logic                                   w_all_ready;
    logic                                   w_can_send;
    logic                                   w_pop;
    logic                                   w_load;
    logic                                   w_drop_next;

    gin_state_t                             r_state;
    gin_state_t                             w_state_next;
    logic [DATA_WIDTH-1:0]                  r_data_out;
    logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] r_send_mask;
    logic                                   r_drop;

    gin_sync_fifo #(
        .WIDTH (c_tag_width),
        .DEPTH (GIN_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (tags_wr_en),
        .i_wr_data ({col_tag, row_tag}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_tag_head),
        .o_full    (tags_full),
        .o_empty   (w_tags_empty)
    );

    gin_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (GIN_FIFO_DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (data_wr_en),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_data_head),
        .o_full    (data_full),
        .o_empty   (w_data_empty)
    );

    assign w_head_row = w_tag_head[ROW_TAG_WIDTH-1:0];
    assign w_head_col = w_tag_head[c_tag_width-1:ROW_TAG_WIDTH];

`ifdef GIN_BROADCAST_EN
    localparam logic [ROW_TAG_WIDTH-1:0] c_row_wild = ROW_TAG_WIDTH'(gin_wildcard(ROW_TAG_WIDTH));
    localparam logic [COL_TAG_WIDTH-1:0] c_col_wild = COL_TAG_WIDTH'(gin_wildcard(COL_TAG_WIDTH));
    assign w_row_wild = (w_head_row == c_row_wild);
    assign w_col_wild = (w_head_col == c_col_wild);
`else
    assign w_row_wild = 1'b0;
    assign w_col_wild = 1'b0;
`endif

    for (genvar r = 0; r < NUM_OF_ROWS; r++) begin : g_row
        assign w_row_hit[r] = (row_id[r] == w_head_row) | w_row_wild;
        for (genvar c = 0; c < NUM_OF_COLS; c++) begin : g_col
            assign w_hit[r][c] = w_row_hit[r] &
                                 ((col_id[r][c] == w_head_col) | w_col_wild);
        end
    end

    assign w_pending   = ~w_tags_empty & ~w_data_empty;
    assign w_any_hit   = |w_hit;
    assign w_all_ready = &(~w_hit | ready_in);
    assign w_can_send  = w_pending & w_any_hit & w_all_ready;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= GIN_IDLE;
        else
            r_state <= w_state_next;
    end

    // Every state re-evaluates the current head, which is what allows back-to-back sends.
    always_comb begin
        w_state_next = GIN_IDLE;
        if (w_can_send)
            w_state_next = GIN_SEND;
        else if (w_pending && !w_any_hit)
            w_state_next = GIN_IDLE;
        else if (w_pending)
            w_state_next = GIN_WAIT;
    end

    always_comb begin
        w_load      = w_can_send;
        w_drop_next = w_pending & ~w_any_hit;
        w_pop       = w_load | w_drop_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_send_mask <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= w_drop_next;
            if (w_load) begin
                r_data_out  <= w_data_head;
                r_send_mask <= w_hit;
            end
        end
    end

    assign data_out   = r_data_out;
    assign enable_out = (r_state == GIN_SEND) ? r_send_mask : '0;
    assign drop_pulse = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_gin_scatter_fifo.sv
// ============================================================================
// Module      : tb_gin_scatter_fifo
// Description : Directed self-checking bench for gin_scatter_fifo; honours
//               GIN_BROADCAST_EN for the wildcard case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gin_scatter_fifo;

    localparam int c_dw = 64;
    localparam int c_rw = 4;
    localparam int c_cw = 4;
    localparam int c_nr = 12;
    localparam int c_nc = 14;

    typedef logic [c_nr-1:0][c_nc-1:0] pe_vec_t;

    logic                                   r_clk = 1'b0;
    logic                                   r_reset;
    logic [c_rw-1:0]                        r_row_tag;
    logic [c_cw-1:0]                        r_col_tag;
    logic                                   r_tags_wr_en;
    logic                                   r_data_wr_en;
    logic [c_dw-1:0]                        r_data_in;
    logic [c_nr-1:0][c_rw-1:0]              r_row_id;
    logic [c_nr-1:0][c_nc-1:0][c_cw-1:0]    r_col_id;
    pe_vec_t                                r_ready;
    wire                                    w_tags_full;
    wire                                    w_data_full;
    wire  [c_dw-1:0]                        w_data_out;
    pe_vec_t                                w_enable;
    wire                                    w_drop;

    int n_cmp = 0;
    int n_err = 0;

    gin_scatter_fifo dut (
        .clk        (r_clk),
        .reset      (r_reset),
        .row_tag    (r_row_tag),
        .col_tag    (r_col_tag),
        .tags_wr_en (r_tags_wr_en),
        .tags_full  (w_tags_full),
        .data_in    (r_data_in),
        .data_wr_en (r_data_wr_en),
        .data_full  (w_data_full),
        .row_id     (r_row_id),
        .col_id     (r_col_id),
        .ready_in   (r_ready),
        .data_out   (w_data_out),
        .enable_out (w_enable),
        .drop_pulse (w_drop)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    function automatic pe_vec_t oh(input int r, input int c);
        pe_vec_t v;
        v = '0;
        v[r][c] = 1'b1;
        return v;
    endfunction

    task automatic set_push(input logic [c_rw-1:0] rt, input logic [c_cw-1:0] ct,
                            input logic [c_dw-1:0] d);
        r_row_tag    = rt;
        r_col_tag    = ct;
        r_data_in    = d;
        r_tags_wr_en = 1'b1;
        r_data_wr_en = 1'b1;
    endtask

    task automatic clr_push();
        r_tags_wr_en = 1'b0;
        r_data_wr_en = 1'b0;
    endtask

    initial begin
        r_reset = 1'b0;
        r_row_tag = '0;
        r_col_tag = '0;
        r_data_in = '0;
        clr_push();
        r_ready = '1;
        for (int r = 0; r < c_nr; r++) begin
            r_row_id[r] = c_rw'(r);
            for (int c = 0; c < c_nc; c++)
                r_col_id[r][c] = c_cw'(c);
        end

        // Reset state
        tick();
        tick();
        check_val("rst_enable", w_enable, '0);
        check_val("rst_data", w_data_out, '0);
        check_val("rst_drop", w_drop, 1'b0);
        check_val("rst_tags_full", w_tags_full, 1'b0);
        check_val("rst_data_full", w_data_full, 1'b0);
        r_reset = 1'b1;
        tick();

        // Single delivery, 2-cycle latency
        set_push(4'd3, 4'd5, 64'hA5A5);
        tick();
        clr_push();
        check_val("t1_lat1_enable", w_enable, '0);
        tick();
        check_val("t1_enable", w_enable, oh(3, 5));
        check_val("t1_data", w_data_out, 64'hA5A5);
        tick();
        check_val("t1_enable_off", w_enable, '0);
        check_val("t1_data_hold", w_data_out, 64'hA5A5);

        // Multicast with one PE stalling for 4 cycles
        r_col_id[3][6] = 4'd5;
        r_ready[3][6]  = 1'b0;
        set_push(4'd3, 4'd5, 64'h1111);
        tick();
        clr_push();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t2_wait_enable", w_enable, '0);
        end
        r_ready[3][6] = 1'b1;
        tick();
        check_val("t2_enable", w_enable, oh(3, 5) | oh(3, 6));
        check_val("t2_data", w_data_out, 64'h1111);
        tick();
        check_val("t2_enable_off", w_enable, '0);
        r_col_id[3][6] = 4'd6;

        // Unmatched tag dropped, following packet delivered
        r_col_id[9][9] = 4'hE;
        set_push(4'd9, 4'd9, 64'h99);
        tick();
        set_push(4'd2, 4'd2, 64'h2222);
        tick();
        clr_push();
        check_val("t3_drop", w_drop, 1'b1);
        check_val("t3_drop_enable", w_enable, '0);
        check_val("t3_drop_data_hold", w_data_out, 64'h1111);
        tick();
        check_val("t3_drop_off", w_drop, 1'b0);
        check_val("t3_next_enable", w_enable, oh(2, 2));
        check_val("t3_next_data", w_data_out, 64'h2222);
        tick();
        r_col_id[9][9] = 4'd9;

        // Fill to full, 17th push ignored, drain back-to-back in order
        r_ready = '0;
        for (int i = 0; i < 16; i++) begin
            set_push(c_rw'(i % 12), c_cw'(i % 14), 64'h1000 + 64'(i));
            tick();
        end
        clr_push();
        check_val("t4_tags_full", w_tags_full, 1'b1);
        check_val("t4_data_full", w_data_full, 1'b1);
        set_push(4'd5, 4'd5, 64'hDEAD);
        tick();
        clr_push();
        check_val("t4_full_hold", w_tags_full, 1'b1);
        check_val("t4_wait_enable", w_enable, '0);
        r_ready = '1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("t4_drain_enable", w_enable, oh(i % 12, i % 14));
            check_val("t4_drain_data", w_data_out, 64'h1000 + 64'(i));
        end
        tick();
        check_val("t4_after_enable", w_enable, '0);
        check_val("t4_after_tags_full", w_tags_full, 1'b0);
        check_val("t4_after_data_full", w_data_full, 1'b0);

        // All-ones tag: broadcast when enabled, literal (no match) otherwise
        set_push(4'hF, 4'hF, 64'hFFFF);
        tick();
        clr_push();
        tick();
`ifdef GIN_BROADCAST_EN
        check_val("t5_bcast_enable", w_enable, {(c_nr*c_nc){1'b1}});
        check_val("t5_bcast_drop", w_drop, 1'b0);
        check_val("t5_bcast_data", w_data_out, 64'hFFFF);
`else
        check_val("t5_literal_enable", w_enable, '0);
        check_val("t5_literal_drop", w_drop, 1'b1);
`endif
        tick();

        // Reset during back-to-back sends flushes everything
        r_ready = '0;
        for (int i = 1; i <= 4; i++) begin
            set_push(c_rw'(i), c_cw'(i), 64'h4000 + 64'(i));
            tick();
        end
        clr_push();
        r_ready = '1;
        tick();
        check_val("t6_first_enable", w_enable, oh(1, 1));
        r_reset = 1'b0;
        tick();
        check_val("t6_rst_enable", w_enable, '0);
        check_val("t6_rst_data", w_data_out, '0);
        check_val("t6_rst_tags_full", w_tags_full, 1'b0);
        r_reset = 1'b1;
        tick();
        check_val("t6_flushed_enable_a", w_enable, '0);
        tick();
        check_val("t6_flushed_enable_b", w_enable, '0);
        check_val("t6_flushed_drop", w_drop, 1'b0);
        set_push(4'd6, 4'd6, 64'h6666);
        tick();
        clr_push();
        tick();
        check_val("t6_post_enable", w_enable, oh(6, 6));
        check_val("t6_post_data", w_data_out, 64'h6666);
        tick();
        check_val("t6_post_enable_off", w_enable, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
